// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with a bounded hold time.
// One requester at a time owns the shared resource. Ownership ends when the
// owner signals done, drops its request, or has held for MAX_HOLD cycles.
// After every release there is one idle cycle before the next grant. The
// search for the next owner starts just after the previous owner.
module rr_arb8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:7] req,
  input  logic       done,
  output logic [0:7] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [0:7] grant_q, grant_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;

  logic       found;
  logic [2:0] winner;
  logic       releaseNow;

  // Find the first active request in the order ptr, ptr+1, ..., ptr+7 (mod 8).
  always_comb begin
    logic [2:0] cand;
    found  = 1'b0;
    winner = ptr_q;
    cand   = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr_q + 3'(i);
      if (req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Ownership ends on done, on the owner dropping its request, or on hold expiry.
  always_comb begin
    releaseNow = done | ~req[idx_q] | (hold_q == HOLD_LIMIT);
  end

  // State register together with the registered outputs and arbitration state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      hold_q  <= 4'd0;
      grant_q <= 8'b0;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: grant from idle when anyone asks, return to idle on release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (found) state_d = BUSY;
      BUSY: if (releaseNow) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the grant outputs, hold counter and priority pointer.
  always_comb begin
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          hold_d          = 4'd1;
          grant_d         = 8'b0;
          grant_d[winner] = 1'b1;
          idx_d           = winner;
          valid_d         = 1'b1;
        end else begin
          hold_d  = 4'd0;
          grant_d = 8'b0;
          valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (releaseNow) begin
          hold_d  = 4'd0;
          grant_d = 8'b0;
          valid_d = 1'b0;
          ptr_d   = idx_q + 3'd1;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        hold_d  = 4'd0;
        grant_d = 8'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed testbench for the rr_arb8 round-robin arbiter (MAX_HOLD = 4).
// Inputs change and outputs are sampled on the falling clock edge, so each
// check sees the result of the preceding rising edge.
module tb_rr_arb8;

  logic       clk;
  logic       rst;
  logic [0:7] req;
  logic       done;
  logic [0:7] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;

  int total = 0;
  int bad   = 0;

  rr_arb8 #(.MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [0:7] decode(input logic [2:0] idx);
    logic [0:7] d;
    d      = 8'b0;
    d[idx] = 1'b1;
    return d;
  endfunction

  // Structural invariants on every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      assert ($onehot0(grant)) else begin
        bad++;
        $error("[TB] FAIL onehot: grant=%b required one-hot-or-zero", grant);
      end
      total++;
      assert (grant_valid === (|grant)) else begin
        bad++;
        $error("[TB] FAIL validMatch: grant_valid=%b required %b", grant_valid, |grant);
      end
      if (grant_valid) begin
        total++;
        assert (grant === decode(grant_idx)) else begin
          bad++;
          $error("[TB] FAIL decode: grant=%b required %b", grant, decode(grant_idx));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [0:7] reqV, input logic doneV);
    req  = reqV;
    done = doneV;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [0:7] expGrant,
                             input logic [2:0] expIdx, input logic expValid);
    total++;
    assert (grant === expGrant) else begin
      bad++;
      $error("[TB] FAIL %s grant: got %b required %b", tag, grant, expGrant);
    end
    total++;
    assert (grant_idx === expIdx) else begin
      bad++;
      $error("[TB] FAIL %s grant_idx: got %0d required %0d", tag, grant_idx, expIdx);
    end
    total++;
    assert (grant_valid === expValid) else begin
      bad++;
      $error("[TB] FAIL %s grant_valid: got %b required %b", tag, grant_valid, expValid);
    end
  endtask

  // Reset pulse placed between clock edges; returns on the next falling edge.
  task automatic resetPulse();
    req  = 8'b0;
    done = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'b0;
    done = 1'b0;
    #2;
    checkOutput("reset", 8'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester 0: held 4 cycles, one idle cycle, then re-granted.
    applyStimulus(8'b1000_0000, 1'b0);
    checkOutput("r0_hold1", 8'b1000_0000, 3'd0, 1'b1);
    applyStimulus(8'b1000_0000, 1'b0);
    checkOutput("r0_hold2", 8'b1000_0000, 3'd0, 1'b1);
    applyStimulus(8'b1000_0000, 1'b0);
    checkOutput("r0_hold3", 8'b1000_0000, 3'd0, 1'b1);
    applyStimulus(8'b1000_0000, 1'b0);
    checkOutput("r0_hold4", 8'b1000_0000, 3'd0, 1'b1);
    applyStimulus(8'b1000_0000, 1'b0);
    checkOutput("r0_expire", 8'b0, 3'd0, 1'b0);
    applyStimulus(8'b1000_0000, 1'b0);
    checkOutput("r0_regrant", 8'b1000_0000, 3'd0, 1'b1);
    applyStimulus(8'b0, 1'b0);
    checkOutput("r0_drop", 8'b0, 3'd0, 1'b0);
    applyStimulus(8'b0, 1'b1);
    checkOutput("idle_done", 8'b0, 3'd0, 1'b0);

    // All requesting, done pulsed each owning cycle: full rotation 0..7,0.
    resetPulse();
    req = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      applyStimulus(8'hFF, 1'b0);
      checkOutput($sformatf("rot_grant%0d", k), 8'b1000_0000 >> (k % 8), 3'(k % 8), 1'b1);
      applyStimulus(8'hFF, 1'b1);
      checkOutput($sformatf("rot_gap%0d", k), 8'b0, 3'(k % 8), 1'b0);
    end
    // done held high through idle is ignored there, then releases owner 1.
    applyStimulus(8'hFF, 1'b1);
    checkOutput("done_idle_grant", 8'b0100_0000, 3'd1, 1'b1);
    applyStimulus(8'b0, 1'b0);
    checkOutput("done_idle_rel", 8'b0, 3'd1, 1'b0);

    // Owner 7 released with 0 and 6 waiting: pointer wraps to 0.
    resetPulse();
    applyStimulus(8'b0000_0001, 1'b0);
    checkOutput("wrap_own7", 8'b0000_0001, 3'd7, 1'b1);
    applyStimulus(8'b1000_0011, 1'b1);
    checkOutput("wrap_rel", 8'b0, 3'd7, 1'b0);
    applyStimulus(8'b1000_0011, 1'b0);
    checkOutput("wrap_grant0", 8'b1000_0000, 3'd0, 1'b1);
    applyStimulus(8'b0, 1'b0);

    // Owner 2 drops request after 2 cycles; 5 is next.
    resetPulse();
    applyStimulus(8'b0010_0100, 1'b0);
    checkOutput("drop_own2a", 8'b0010_0000, 3'd2, 1'b1);
    applyStimulus(8'b0010_0100, 1'b0);
    checkOutput("drop_own2b", 8'b0010_0000, 3'd2, 1'b1);
    applyStimulus(8'b0000_0100, 1'b0);
    checkOutput("drop_rel", 8'b0, 3'd2, 1'b0);
    applyStimulus(8'b0000_0100, 1'b0);
    checkOutput("drop_grant5", 8'b0000_0100, 3'd5, 1'b1);
    // Owner 5 held to expiry, done raised on the same edge: one release.
    applyStimulus(8'b0000_0100, 1'b0);
    checkOutput("own5_h2", 8'b0000_0100, 3'd5, 1'b1);
    applyStimulus(8'b0000_0100, 1'b0);
    checkOutput("own5_h3", 8'b0000_0100, 3'd5, 1'b1);
    applyStimulus(8'b0000_0100, 1'b0);
    checkOutput("own5_h4", 8'b0000_0100, 3'd5, 1'b1);
    applyStimulus(8'b0001_0100, 1'b1);
    checkOutput("own5_rel", 8'b0, 3'd5, 1'b0);
    // Pointer now 6: search 6,7,0,1,2,3 finds 3 before 5.
    applyStimulus(8'b0001_0100, 1'b0);
    checkOutput("ptr6_grant3", 8'b0001_0000, 3'd3, 1'b1);
    applyStimulus(8'b0, 1'b0);

    // Asynchronous reset while 4 owns; afterwards 1 wins over 4.
    resetPulse();
    applyStimulus(8'b0000_1000, 1'b0);
    checkOutput("own4", 8'b0000_1000, 3'd4, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst", 8'b0, 3'd0, 1'b0);
    req = 8'b0100_1000;
    @(negedge clk);
    checkOutput("rst_held", 8'b0, 3'd0, 1'b0);
    rst = 1'b0;
    applyStimulus(8'b0100_1000, 1'b0);
    checkOutput("post_rst_grant1", 8'b0100_0000, 3'd1, 1'b1);
    applyStimulus(8'b0, 1'b0);
    checkOutput("post_rst_rel", 8'b0, 3'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter: MAX_HOLD, default 4, meaning maximum consecutive grant cycles per ownership, legal range 1..15.
REQ-002 Port: clk  input  1  single system clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: req  input  [0:7]  request lines; req[i] high = requester i wants the shared resource.
REQ-005 Port: done  input  1  owner releases the resource this cycle.
REQ-006 Port: grant  output  [0:7]  one-hot grant; grant[i] high = requester i owns the resource.
REQ-007 Port: grant_idx  output  [2:0]  binary index of current owner, i.e. grant == decode(grant_idx) when grant_valid.
REQ-008 Port: grant_valid  output  1  high while any grant bit is high.

Function
REQ-009 Two states SHALL exist: IDLE (no owner) and BUSY (one owner); grant, grant_idx and grant_valid SHALL be registered outputs.
REQ-010 A 3-bit priority pointer ptr SHALL hold the index searched first; search order ptr, ptr+1, ..., ptr+7, mod 8.
REQ-011 IDLE, req != 0 at edge: first requester k in search order SHALL be granted; BUSY entered; grant[k]=1, grant_idx=k, grant_valid=1 visible after that edge (latency 1 cycle from req to grant).
REQ-012 IDLE, req == 0: remain IDLE, grant=8'b0, grant_idx holds last value, grant_valid=0.
REQ-013 BUSY SHALL hold owner k unchanged while req[k]=1, done=0 and hold count < MAX_HOLD; other requests SHALL be ignored.
REQ-014 Hold counter (4 bits) SHALL load 1 on entry to BUSY and increment every BUSY cycle; saturation never needed since MAX_HOLD <= 15.
REQ-015 Release SHALL occur at the edge where any of: done=1, req[k]=0, or hold count == MAX_HOLD; state -> IDLE, grant cleared, ptr <- k+1 mod 8.
REQ-016 After every release exactly one IDLE cycle with grant_valid=0 SHALL occur before the next grant (no back-to-back handover).
REQ-017 ptr wrap-around: owner 7 released -> ptr = 0.
REQ-018 ptr SHALL change only on release, never on grant or in idle.
REQ-019 done asserted while IDLE SHALL be ignored.
REQ-020 Simultaneous done=1 and hold-count expiry SHALL produce a single release identical to REQ-015.
REQ-021 grant SHALL never have more than one bit set in any cycle.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, grant=8'b0, grant_idx=3'd0, grant_valid=0, ptr=3'd0, hold count=0.
REQ-023 rst asserted mid-ownership SHALL drop the grant asynchronously; after deassertion arbitration restarts from ptr=0.
REQ-024 First grant after rst deassertion SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-025 Reset then req=8'b1000_0000 (requester 0 only), done=0 -> next cycle grant[0]=1, grant_idx=0; released after 4 cycles (MAX_HOLD=4), one idle cycle, re-granted to 0.
REQ-026 req=all ones held, done pulsed each owning cycle -> grant_idx sequence 0,1,2,...,7,0 with one grant_valid=0 cycle between each.
REQ-027 Owner 7 released with req[0] and req[6] high -> next grant_idx=0 (wrap), not 6.
REQ-028 Owner 2 with req[2] dropped after 2 cycles, req[5] high -> release at that edge, ptr=3, next grant_idx=5 after one idle cycle.
REQ-029 rst pulsed between clock edges while grant_idx=4 -> grant=0, grant_valid=0 immediately; with req[4] and req[1] high after rst release -> grant_idx=1.
REQ-030 All scenarios: checker asserts grant one-hot-or-zero and grant == decode(grant_idx) whenever grant_valid=1.
